// File: rtl/dispense_ctrl.sv
// Vending dispense controller: pay/request -> stock check -> motor pulse -> done or refund.
// Optional drop-sensor confirmation and jam lockout are built when DISPENSE_SENSE_EN is defined.
module dispense_ctrl #(
  parameter int NUM_SLOTS     = 4,
  parameter int STOCK_W       = 4,
  parameter int PULSE_CYCLES  = 8,
  parameter int SENSE_TIMEOUT = 16,
  parameter int SEL_W         = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [SEL_W-1:0]     req_slot,
  input  logic                 payment_ok,
  input  logic                 restock_valid,
  input  logic [SEL_W-1:0]     restock_slot,
  input  logic [STOCK_W-1:0]   restock_qty,
  input  logic                 drop_sense,
  input  logic                 clr_jam,
  output logic                 req_ready,
  output logic [NUM_SLOTS-1:0] motor,
  output logic                 done,
  output logic                 refund,
  output logic                 jam,
  output logic [NUM_SLOTS-1:0] stock_empty
);

  localparam int CNT_MAX = (PULSE_CYCLES > SENSE_TIMEOUT) ? PULSE_CYCLES : SENSE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, CHECK, PULSE, SENSE, DONE} state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       slot_q, slot_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0]   motor_q, motor_d;
  logic                   done_q, done_d;
  logic                   refund_q, refund_d;
  logic                   jam_q, jam_d;
  logic [STOCK_W-1:0]     stock_q [NUM_SLOTS];
  logic [STOCK_W-1:0]     stock_d [NUM_SLOTS];

  logic [NUM_SLOTS-1:0]   slot_oh, restock_oh;
  logic [STOCK_W-1:0]     slot_stock;
  logic                   slot_ok;
  logic                   dec_en;
  logic [STOCK_W:0]       sum;

  // Out-of-range indices decode to an all-zero one-hot, which makes them unsellable and unrestockable.
  always_comb begin
    slot_oh    = '0;
    restock_oh = '0;
    slot_stock = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_oh[i]    = (32'(slot_q) == i);
      restock_oh[i] = restock_valid && (32'(restock_slot) == i);
      if (slot_oh[i]) slot_stock = stock_q[i];
    end
    slot_ok = (|slot_oh) && (slot_stock != '0);
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    motor_d  = motor_q;
    done_d   = 1'b0;
    refund_d = 1'b0;
    jam_d    = jam_q;
    dec_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && payment_ok && req_ready) begin
          slot_d  = req_slot;
          state_d = CHECK;
        end
`ifdef DISPENSE_SENSE_EN
        if (clr_jam) jam_d = 1'b0;
`endif
      end
      CHECK: begin
        if (slot_ok) begin
          dec_en  = 1'b1;
          motor_d = slot_oh;
          cnt_d   = '0;
          state_d = PULSE;
        end else begin
          refund_d = 1'b1;
          state_d  = IDLE;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          motor_d = '0;
          cnt_d   = '0;
`ifdef DISPENSE_SENSE_EN
          state_d = SENSE;
`else
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef DISPENSE_SENSE_EN
      SENSE: begin
        if (drop_sense) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(SENSE_TIMEOUT - 1)) begin
          refund_d = 1'b1;
          jam_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decrement and restock fold into one add so a coincident pair saturates on the net result.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      sum = {1'b0, stock_q[i]}
          - (STOCK_W+1)'(dec_en && slot_oh[i])
          + (restock_oh[i] ? {1'b0, restock_qty} : '0);
      stock_d[i] = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      cnt_q    <= '0;
      motor_q  <= '0;
      done_q   <= 1'b0;
      refund_q <= 1'b0;
      jam_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) stock_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      motor_q  <= motor_d;
      done_q   <= done_d;
      refund_q <= refund_d;
      jam_q    <= jam_d;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) stock_q[i] <= stock_d[i];
    end
  end

`ifndef DISPENSE_SENSE_EN
  logic unused_sense;
  assign unused_sense = drop_sense ^ clr_jam;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) stock_empty[i] = (stock_q[i] == '0);
  end

  assign req_ready = (state_q == IDLE) && !jam_q;
  assign motor     = motor_q;
  assign done      = done_q;
  assign refund    = refund_q;
  assign jam       = jam_q;

endmodule
